// File: rtl/piece_sequencer.sv
// ============================================================================
//  Module      : piece_sequencer
//  Description : Falling-tetromino controller. Owns the active piece
//                (x, y, type, dir), serialises gravity and button requests
//                into one trial move at a time, runs each trial past the
//                board collision checker, commits or discards the result,
//                hands failed drops to the board for locking, spawns new
//                pieces from an 8-bit LFSR and detects game over.
//  Options     : define HARD_DROP_EN to enable the space-bar hard drop.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module piece_sequencer #(
  parameter int         SPAWN_X   = 4,
  parameter int         SPAWN_Y   = 0,
  parameter int         X_MAX     = 9,
  parameter int         Y_MAX     = 19,
  parameter logic [7:0] LFSR_SEED = 8'h5A
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       enter,
  input  logic       tick,
  input  logic       up,
  input  logic       down,
  input  logic       left,
  input  logic       right,
  input  logic       space,
  output logic       chk_req,
  output logic [4:0] chk_x,
  output logic [4:0] chk_y,
  output logic [2:0] chk_type,
  output logic [1:0] chk_dir,
  input  logic       chk_valid,
  input  logic       chk_ok,
  output logic       lock_req,
  input  logic       lock_ack,
  output logic [4:0] x,
  output logic [4:0] y,
  // "type" is a reserved word, so the committed piece type is piece_type.
  output logic [2:0] piece_type,
  output logic [1:0] dir,
  output logic       game_over
);

  localparam logic [4:0] X_LAST  = 5'(X_MAX);
  localparam logic [4:0] Y_LAST  = 5'(Y_MAX);
  localparam logic [4:0] X_SPAWN = 5'(SPAWN_X);
  localparam logic [4:0] Y_SPAWN = 5'(SPAWN_Y);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SPAWN    = 3'd1,
    S_READY    = 3'd2,
    S_WAIT_CHK = 3'd3,
    S_LOCK     = 3'd4,
    S_OVER     = 3'd5
  } state_t;

  // Kind of trial currently in flight; decides how the checker result is used.
  typedef enum logic [2:0] {
    OP_SPAWN = 3'd0,
    OP_DROP  = 3'd1,
    OP_ROT   = 3'd2,
    OP_LEFT  = 3'd3,
    OP_RIGHT = 3'd4,
    OP_HARD  = 3'd5
  } op_t;

  state_t     state, state_n;
  op_t        op, op_n;
  logic [7:0] lfsr;
  logic [2:0] spawn_type;
  logic [4:0] x_n, y_n, tx, tx_n, ty, ty_n;
  logic [1:0] dir_n, tdir, tdir_n;
  logic [2:0] type_n;
  logic       p_drop, p_rot, p_left, p_right;
  logic       clr_drop, clr_rot, clr_left, clr_right, clr_hard;
  logic       hard_pend;
  logic       set_en;

  // lfsr value 7 is not a tetromino; fold it onto type 0
  assign spawn_type = (lfsr[2:0] == 3'd7) ? 3'd0 : lfsr[2:0];

  // Requests are only latched while a game is in progress.
  assign set_en = (state != S_IDLE) && (state != S_OVER);

  assign chk_req   = (state == S_WAIT_CHK);
  assign lock_req  = (state == S_LOCK);
  assign game_over = (state == S_OVER);
  assign chk_x     = tx;
  assign chk_y     = ty;
  assign chk_dir   = tdir;
  assign chk_type  = piece_type;

`ifdef HARD_DROP_EN
  logic p_hard;

  // Hard-drop request bit, outranking every other request.
  always_ff @(posedge clk) begin
    if (!rstn)                  p_hard <= 1'b0;
    else if (state_n == S_SPAWN) p_hard <= 1'b0;
    else                        p_hard <= (p_hard & ~clr_hard) | (set_en & space);
  end

  assign hard_pend = p_hard;
`else
  logic unused_space;

  assign unused_space = space | clr_hard;
  assign hard_pend    = 1'b0;
`endif

  // State register plus piece, trial, pending and LFSR registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= S_IDLE;
      op         <= OP_SPAWN;
      lfsr       <= LFSR_SEED;
      x          <= 5'd0;
      y          <= 5'd0;
      dir        <= 2'd0;
      piece_type <= 3'd0;
      tx         <= 5'd0;
      ty         <= 5'd0;
      tdir       <= 2'd0;
      p_drop     <= 1'b0;
      p_rot      <= 1'b0;
      p_left     <= 1'b0;
      p_right    <= 1'b0;
    end else begin
      state      <= state_n;
      op         <= op_n;
      lfsr       <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      x          <= x_n;
      y          <= y_n;
      dir        <= dir_n;
      piece_type <= type_n;
      tx         <= tx_n;
      ty         <= ty_n;
      tdir       <= tdir_n;
      // A pulse in the same cycle its bit is served re-arms the bit.
      if (state_n == S_SPAWN) begin
        p_drop  <= 1'b0;
        p_rot   <= 1'b0;
        p_left  <= 1'b0;
        p_right <= 1'b0;
      end else begin
        p_drop  <= (p_drop  & ~clr_drop)  | (set_en & (tick | down));
        p_rot   <= (p_rot   & ~clr_rot)   | (set_en & up);
        p_left  <= (p_left  & ~clr_left)  | (set_en & left);
        p_right <= (p_right & ~clr_right) | (set_en & right);
      end
    end
  end

  // Next-state logic: request arbitration, trial construction, result handling.
  always_comb begin
    state_n   = state;
    op_n      = op;
    x_n       = x;
    y_n       = y;
    dir_n     = dir;
    type_n    = piece_type;
    tx_n      = tx;
    ty_n      = ty;
    tdir_n    = tdir;
    clr_drop  = 1'b0;
    clr_rot   = 1'b0;
    clr_left  = 1'b0;
    clr_right = 1'b0;
    clr_hard  = 1'b0;
    case (state)
      S_IDLE: begin
        if (enter) state_n = S_SPAWN;
      end
      S_SPAWN: begin
        x_n     = X_SPAWN;
        y_n     = Y_SPAWN;
        dir_n   = 2'd0;
        type_n  = spawn_type;
        tx_n    = X_SPAWN;
        ty_n    = Y_SPAWN;
        tdir_n  = 2'd0;
        op_n    = OP_SPAWN;
        state_n = S_WAIT_CHK;
      end
      S_READY: begin
        tx_n   = x;
        ty_n   = y;
        tdir_n = dir;
        if (hard_pend) begin
          clr_hard = 1'b1;
          if (y == Y_LAST) begin
            state_n = S_LOCK;
          end else begin
            ty_n    = y + 5'd1;
            op_n    = OP_HARD;
            state_n = S_WAIT_CHK;
          end
        end else if (p_drop) begin
          clr_drop = 1'b1;
          if (y == Y_LAST) begin
            state_n = S_LOCK;
          end else begin
            ty_n    = y + 5'd1;
            op_n    = OP_DROP;
            state_n = S_WAIT_CHK;
          end
        end else if (p_rot) begin
          clr_rot = 1'b1;
          tdir_n  = dir + 2'd1;
          op_n    = OP_ROT;
          state_n = S_WAIT_CHK;
        end else if (p_left) begin
          clr_left = 1'b1;
          if (x != 5'd0) begin
            tx_n    = x - 5'd1;
            op_n    = OP_LEFT;
            state_n = S_WAIT_CHK;
          end
        end else if (p_right) begin
          clr_right = 1'b1;
          if (x != X_LAST) begin
            tx_n    = x + 5'd1;
            op_n    = OP_RIGHT;
            state_n = S_WAIT_CHK;
          end
        end
      end
      S_WAIT_CHK: begin
        if (chk_valid) begin
          if (op == OP_SPAWN) begin
            state_n = chk_ok ? S_READY : S_OVER;
          end else if (chk_ok) begin
            x_n   = tx;
            y_n   = ty;
            dir_n = tdir;
            if (op != OP_HARD) begin
              state_n = S_READY;
            end else if (ty == Y_LAST) begin
              state_n = S_LOCK;
            end else begin
              // keep falling: next trial goes straight back to the checker
              ty_n = ty + 5'd1;
            end
          end else if ((op == OP_DROP) || (op == OP_HARD)) begin
            state_n = S_LOCK;
          end else begin
            state_n = S_READY;
          end
        end
      end
      S_LOCK: begin
        if (lock_ack) state_n = S_SPAWN;
      end
      S_OVER: begin
        if (enter) state_n = S_SPAWN;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_piece_sequencer.sv
// ============================================================================
//  Module      : tb_piece_sequencer
//  Description : Randomised scoreboard bench for piece_sequencer. A
//                transaction-level game model predicts every checker and
//                lock transaction; a monitor/responder pops and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_piece_sequencer;

  localparam logic [7:0] SEED = 8'h5A;
  localparam int K_CHK = 0, K_SPAWN = 1, K_LOCK = 2;
  localparam int OP_HARD = 0, OP_DROP = 1, OP_ROT = 2, OP_LEFT = 3, OP_RIGHT = 4;

  typedef struct {
    int kind;
    int px;
    int py;
    int pdir;
    bit ok;
  } item_t;

  logic clk = 1'b0, rstn = 1'b0, enter = 1'b0, tick = 1'b0, up = 1'b0;
  logic down = 1'b0, left = 1'b0, right = 1'b0, space = 1'b0;
  logic chk_valid = 1'b0, chk_ok = 1'b0, lock_ack = 1'b0;
  logic       chk_req, lock_req, game_over;
  logic [4:0] chk_x, chk_y, x, y;
  logic [2:0] chk_type, piece_type;
  logic [1:0] chk_dir, dir;

  piece_sequencer dut (
    .clk(clk), .rstn(rstn), .enter(enter), .tick(tick), .up(up), .down(down),
    .left(left), .right(right), .space(space), .chk_req(chk_req),
    .chk_x(chk_x), .chk_y(chk_y), .chk_type(chk_type), .chk_dir(chk_dir),
    .chk_valid(chk_valid), .chk_ok(chk_ok), .lock_req(lock_req),
    .lock_ack(lock_ack), .x(x), .y(y), .piece_type(piece_type), .dir(dir),
    .game_over(game_over)
  );

  always #5 clk = ~clk;

  item_t sb[$];
  int    checks = 0, errors = 0;
  int    m_x = 0, m_y = 0, m_dir = 0, m_type = 0;
  bit    m_over = 1'b0;
  bit    resp_en = 1'b1;
  int    nrun = 0;

  // clock edges since reset released = LFSR steps taken
  always @(posedge clk) begin
    if (!rstn) nrun <= 0;
    else       nrun <= nrun + 1;
  end

  function automatic logic [7:0] lfsr_at(int n);
    logic [7:0] v = SEED;
    for (int i = 0; i < n; i++) v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    return v;
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic finish_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  // Monitor / responder: pops the expected transaction whenever the DUT asks.
  initial begin : monitor
    item_t      it;
    logic [7:0] v;
    int         t;
    forever begin
      @(negedge clk);
      if (rstn && resp_en) begin
        if (chk_req) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_chk_req: got chk_req=1 x=%0d y=%0d dir=%0d expected none",
                     chk_x, chk_y, chk_dir);
            it.ok = 1'b0;
          end else begin
            it = sb.pop_front();
            check("chk_is_trial", int'(it.kind != K_LOCK), 1);
            if (it.kind == K_SPAWN) begin
              v = lfsr_at(nrun - 1);
              t = int'(v[2:0]);
              m_type = (t == 7) ? 0 : t;
            end
            check("chk_x", int'(chk_x), it.px);
            check("chk_y", int'(chk_y), it.py);
            check("chk_dir", int'(chk_dir), it.pdir);
            check("chk_type", int'(chk_type), m_type);
          end
          repeat ($urandom_range(0, 2)) @(negedge clk);
          chk_ok    = it.ok;
          chk_valid = 1'b1;
          @(negedge clk);
          chk_valid = 1'b0;
          chk_ok    = 1'b0;
        end else if (lock_req) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_lock_req: got lock_req=1 expected none");
          end else begin
            it = sb.pop_front();
            check("lock_is_lock", int'(it.kind == K_LOCK), 1);
            check("lock_x", int'(x), it.px);
            check("lock_y", int'(y), it.py);
          end
          repeat ($urandom_range(0, 2)) @(negedge clk);
          lock_ack = 1'b1;
          @(negedge clk);
          lock_ack = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #3000000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    finish_run();
  end

  // ---------------- reference model (transaction level) ----------------
  function automatic bit rnd_ok(int pct);
    return $urandom_range(0, 99) < pct;
  endfunction

  task automatic push(int kind, int px, int py, int pdir, bit ok);
    item_t it;
    it.kind = kind; it.px = px; it.py = py; it.pdir = pdir; it.ok = ok;
    sb.push_back(it);
  endtask

  task automatic model_spawn();
    bit ok = rnd_ok(90);
    m_x = 4; m_y = 0; m_dir = 0;
    push(K_SPAWN, 4, 0, 0, ok);
    if (!ok) m_over = 1'b1;
  endtask

  task automatic model_lock();
    push(K_LOCK, m_x, m_y, m_dir, 1'b0);
    model_spawn();
  endtask

  // Predicts the transactions of one serviced request; ended=1 if the piece locked.
  task automatic model_op(int op, output bit ended);
    bit ok;
    int yt;
    ended = 1'b0;
    case (op)
      OP_HARD: begin
        yt = m_y + 1;
        while (m_y != 19) begin
          ok = rnd_ok(92);
          push(K_CHK, m_x, yt, m_dir, ok);
          if (!ok) break;
          m_y = yt;
          yt++;
        end
        model_lock();
        ended = 1'b1;
      end
      OP_DROP: begin
        if (m_y == 19) begin
          model_lock();
          ended = 1'b1;
        end else begin
          ok = rnd_ok(92);
          push(K_CHK, m_x, m_y + 1, m_dir, ok);
          if (ok) m_y++;
          else begin
            model_lock();
            ended = 1'b1;
          end
        end
      end
      OP_ROT: begin
        ok = rnd_ok(80);
        push(K_CHK, m_x, m_y, (m_dir + 1) % 4, ok);
        if (ok) m_dir = (m_dir + 1) % 4;
      end
      OP_LEFT: begin
        if (m_x != 0) begin
          ok = rnd_ok(85);
          push(K_CHK, m_x - 1, m_y, m_dir, ok);
          if (ok) m_x--;
        end
      end
      default: begin
        if (m_x != 9) begin
          ok = rnd_ok(85);
          push(K_CHK, m_x + 1, m_y, m_dir, ok);
          if (ok) m_x++;
        end
      end
    endcase
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic pulse(bit b_tick, bit b_down, bit b_up, bit b_left, bit b_right,
                       bit b_space, bit b_enter);
    tick = b_tick; down = b_down; up = b_up; left = b_left; right = b_right;
    space = b_space; enter = b_enter;
    @(negedge clk);
    tick = 1'b0; down = 1'b0; up = 1'b0; left = 1'b0; right = 1'b0;
    space = 1'b0; enter = 1'b0;
  endtask

  task automatic settle();
    int n = 0;
    int quiet = 0;
    while (quiet < 3) begin
      @(negedge clk);
      if (sb.size() == 0 && !chk_req && !lock_req && !chk_valid && !lock_ack) quiet++;
      else quiet = 0;
      n++;
      if (n > 600) begin
        errors++;
        $display("FAIL settle_timeout: %0d transactions still expected, chk_req=%0d lock_req=%0d",
                 sb.size(), chk_req, lock_req);
        finish_run();
      end
    end
  endtask

  task automatic check_piece(string tag);
    check({tag, "_x"}, int'(x), m_x);
    check({tag, "_y"}, int'(y), m_y);
    check({tag, "_dir"}, int'(dir), m_dir);
    check({tag, "_type"}, int'(piece_type), m_type);
    check({tag, "_game_over"}, int'(game_over), int'(m_over));
  endtask

  task automatic restart();
    m_over = 1'b0;
    model_spawn();
    pulse(0, 0, 0, 0, 0, 0, 1);
    settle();
    check_piece("spawn");
  endtask

  // ---------------- main stimulus ----------------
  initial begin : stim
    bit [4:0] mask;
    bit       ended;
    bit       use_tick, use_down;
    int       runs;

    repeat (3) @(negedge clk);
    check("rst_x", int'(x), 0);
    check("rst_y", int'(y), 0);
    check("rst_dir", int'(dir), 0);
    check("rst_type", int'(piece_type), 0);
    check("rst_chk_req", int'(chk_req), 0);
    check("rst_lock_req", int'(lock_req), 0);
    check("rst_game_over", int'(game_over), 0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_no_chk", int'(chk_req), 0);

    restart();

    for (int i = 0; i < 300; i++) begin
      if (m_over) begin
        // a dead game must ignore every request but enter
        pulse(1, 1, 1, 1, 1, 1, 0);
        settle();
        check_piece("over");
        restart();
      end else begin
        mask = 5'd0;
        if ($urandom_range(0, 2) == 0) begin
          mask[4:1] = 4'($urandom_range(1, 15));
        end else begin
          case ($urandom_range(0, 9))
            0, 1, 2: mask[OP_DROP]  = 1'b1;
            3, 4:    mask[OP_ROT]   = 1'b1;
            5, 6:    mask[OP_LEFT]  = 1'b1;
            default: mask[OP_RIGHT] = 1'b1;
          endcase
        end
`ifdef HARD_DROP_EN
        if ($urandom_range(0, 7) == 0) mask[OP_HARD] = 1'b1;
`endif
        runs = ($urandom_range(0, 7) == 0) ? (mask[OP_DROP] ? 22 : 7) : 1;
        for (int r = 0; r < runs && !m_over; r++) begin
          ended = 1'b0;
          for (int op = OP_HARD; op <= OP_RIGHT; op++) begin
            if (mask[op] && !ended && !m_over) model_op(op, ended);
          end
          use_tick = mask[OP_DROP] && ($urandom_range(0, 2) != 0);
          use_down = mask[OP_DROP] && (!use_tick || ($urandom_range(0, 1) == 1));
          pulse(use_tick, use_down, mask[OP_ROT], mask[OP_LEFT], mask[OP_RIGHT],
                mask[OP_HARD], 0);
          settle();
          check_piece("move");
        end
      end
    end

    // reset in the middle of a checker handshake
    for (int k = 0; k < 20 && m_over; k++) restart();
    if (!m_over) begin
      resp_en = 1'b0;
      pulse(0, 0, 1, 0, 0, 0, 0);
      repeat (3) @(negedge clk);
      check("hold_chk_req", int'(chk_req), 1);
      check("hold_chk_dir", int'(chk_dir), (m_dir + 1) % 4);
      rstn = 1'b0;
      @(negedge clk);
      check("midrst_chk_req", int'(chk_req), 0);
      check("midrst_lock_req", int'(lock_req), 0);
      check("midrst_x", int'(x), 0);
      check("midrst_y", int'(y), 0);
      check("midrst_game_over", int'(game_over), 0);
      rstn = 1'b1;
      m_x = 0; m_y = 0; m_dir = 0; m_type = 0;
      pulse(1, 0, 1, 1, 1, 1, 0);
      repeat (3) @(negedge clk);
      check("idle_ignores_req", int'(chk_req), 0);
      resp_en = 1'b1;
      restart();
    end

    finish_run();
  end

endmodule

`default_nettype wire

// File: doc/piece_sequencer.md
Name: piece_sequencer

Overview:
- Game-level controller for the falling tetromino: owns the active piece state (x, y, type, dir) and decides when it moves.
- Serialises gravity ticks and player button pulses into one trial move at a time, and sends each trial to the board collision checker over a req/valid handshake.
- Commits accepted trials; on a failed drop, hands the piece to the board for locking and line clear.
- Spawns the next piece from an internal LFSR and detects game over.

Parameters:
- SPAWN_X, 4, column loaded on spawn.
- SPAWN_Y, 0, row loaded on spawn.
- X_MAX, 9, rightmost legal column.
- Y_MAX, 19, bottom legal row.
- LFSR_SEED, 8'h5A, LFSR reset value; must be nonzero.

Ports:
- clk  in  1  system clock
- rstn  in  1  synchronous active-low reset
- enter  in  1  start / restart pulse
- tick  in  1  gravity pulse, one cycle
- up  in  1  rotate request pulse
- down  in  1  soft-drop request pulse
- left  in  1  move-left request pulse
- right  in  1  move-right request pulse
- space  in  1  hard-drop request pulse (see Optional Feature)
- chk_req  out  1  trial valid to collision checker
- chk_x  out  5  trial column
- chk_y  out  5  trial row
- chk_type  out  3  trial type
- chk_dir  out  2  trial rotation
- chk_valid  in  1  checker result valid
- chk_ok  in  1  trial fits; sampled only with chk_valid
- lock_req  out  1  write current piece into board
- lock_ack  in  1  board finished lock and line clear
- x  out  5  committed column
- y  out  5  committed row
- type  out  3  committed type, 0..6
- dir  out  2  committed rotation
- game_over  out  1  game-over flag

Behaviour:
- Single clock, clk. Reset is synchronous and active-low on rstn, sampled at the clk edge.
- Reset values:
  - x=0, y=0, type=0, dir=0
  - chk_req=0, lock_req=0, game_over=0
  - all pending bits cleared
  - LFSR=LFSR_SEED
  - state IDLE
- Reset asserted mid-handshake drops chk_req and lock_req at that edge. Any late chk_valid or lock_ack is then ignored.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4. Advances every cycle outside reset.
- Spawn type = lfsr[2:0], except 7 maps to 0.
- States:
  - IDLE: enter -> SPAWN.
  - SPAWN: load x=SPAWN_X, y=SPAWN_Y, dir=0, type from LFSR. Issue a spawn check (trial = the new piece). -> WAIT_CHK.
  - READY: if any pending bit is set, select one by fixed priority drop > rotate > left > right. Build the trial and go -> WAIT_CHK. Otherwise stay.
  - WAIT_CHK: hold chk_req=1 with trial fields stable until the cycle chk_valid=1. Next cycle chk_req=0 and the result is applied:
    - spawn check ok -> READY; fail -> OVER.
    - move ok -> commit the trial to x/y/dir, visible the cycle after chk_valid, -> READY.
    - move fail, rotate/left/right -> discard, -> READY.
    - move fail, drop -> LOCK.
  - LOCK: lock_req=1 held until lock_ack=1. Next cycle lock_req=0 -> SPAWN.
  - OVER: game_over=1. Inputs ignored except enter, which clears game_over and all pending bits -> SPAWN.
- Pending bits:
  - One bit each: drop (tick OR down), rotate (up), left, right.
  - Set on the input pulse in any state except IDLE/OVER. Multiple pulses before service coalesce into one.
  - A bit is cleared when selected in READY. A pulse arriving in the same cycle it is cleared re-sets the bit, so it is not lost.
  - All pending bits clear on entering SPAWN.
- Trials:
  - rotate: dir+1 mod 4.
  - drop: y+1.
  - left: x-1.
  - right: x+1.
  - type is unchanged for all trials.
- Boundary pre-rejects: no checker transaction is issued and the bit is cleared, staying in READY.
  - left at x==0 is rejected.
  - right at x==X_MAX is rejected.
  - drop at y==Y_MAX goes directly to LOCK.
- chk_valid outside WAIT_CHK and lock_ack outside LOCK are ignored.
- At most one checker transaction is outstanding at a time.

Optional Feature:
- Macro HARD_DROP_EN.
- Defined:
  - space sets a hard pending bit, priority above drop.
  - Service repeats drop trials back-to-back (WAIT_CHK -> WAIT_CHK with y committed each ok), without returning to READY, until fail or y==Y_MAX. Then -> LOCK.
  - Other pending bits are retained but not serviced during the hard drop.
- Undefined: space ignored; no hard pending bit exists.

Test Plan:
- Reset, enter, LFSR type=2: spawn trial chk_x=4 chk_y=0 chk_dir=0, chk_ok=1 -> READY, x=4 y=0 type=2 game_over=0.
- Same cycle: tick, up, left pulses; checker always ok -> trials in order y=1, then dir=1, then x=3, one chk_req each, final x=3 y=1 dir=1.
- x=0, left pulse -> chk_req stays 0, x stays 0. x=9, right pulse -> same, x stays 9.
- tick with chk_ok=0 -> lock_req=1 until lock_ack. Next cycle new spawn trial at (4,0), dir=0.
- Spawn trial chk_ok=0 -> game_over=1; up/left/tick ignored; enter -> game_over=0, spawn trial issued.
- HARD_DROP_EN: y=0, space, checker ok until y=15 then fails on trial y=16 -> 15 consecutive commits, y=15, lock_req=1. rstn low during WAIT_CHK -> next cycle chk_req=0, x=y=0, IDLE.
